mm2s_win_reader: RTL and testbench

//  Single-clock AXI4 read master that fetches a rectangular window (left/top/width/height) out of a

---
 rtl/mm2s_win_reader.sv | 200 ++++++++++++++++++++
 tb/tb_mm2s_win_reader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm2s_win_reader.sv
// AXI4 read master that crops a window out of a strided frame buffer and writes
// {eol,sof,pixel} packed words into the mm2s FIFO, one burst outstanding at a time.
module mm2s_win_reader #(
  parameter int C_PIXEL_WIDTH      = 8,
  parameter int C_IMG_WBITS        = 12,
  parameter int C_IMG_HBITS        = 12,
  parameter int C_M_AXI_BURST_LEN  = 16,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                                  m2f_aclk,
  input  logic                                  resetn,
  input  logic                                  frame_start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]         base_addr,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]         stride,
  input  logic [C_IMG_WBITS-1:0]                win_left,
  input  logic [C_IMG_HBITS-1:0]                win_top,
  input  logic [C_IMG_WBITS-1:0]                win_width,
  input  logic [C_IMG_HBITS-1:0]                win_height,
  output logic                                  busy,
  output logic                                  frame_done,
  output logic                                  rd_err,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]         m_axi_araddr,
  output logic [7:0]                            m_axi_arlen,
  output logic [2:0]                            m_axi_arsize,
  output logic [1:0]                            m_axi_arburst,
  output logic                                  m_axi_arlock,
  output logic [3:0]                            m_axi_arcache,
  output logic [2:0]                            m_axi_arprot,
  output logic [3:0]                            m_axi_arqos,
  output logic                                  m_axi_arvalid,
  input  logic                                  m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]         m_axi_rdata,
  input  logic [1:0]                            m_axi_rresp,
  input  logic                                  m_axi_rlast,
  input  logic                                  m_axi_rvalid,
  output logic                                  m_axi_rready,
  input  logic                                  mm2s_full,
  output logic [(C_M_AXI_DATA_WIDTH/C_PIXEL_WIDTH)*(C_PIXEL_WIDTH+2)-1:0] mm2s_wr_data,
  output logic                                  mm2s_wr_en
);

  localparam int A         = C_M_AXI_ADDR_WIDTH;
  localparam int W         = C_IMG_WBITS;
  localparam int H         = C_IMG_HBITS;
  localparam int P         = C_PIXEL_WIDTH;
  localparam int PPW       = C_M_AXI_DATA_WIDTH / C_PIXEL_WIDTH;
  localparam int SIZE      = $clog2(C_M_AXI_DATA_WIDTH / 8);
  localparam int PIX_SHIFT = $clog2(P / 8);
  localparam int PPW_SHIFT = $clog2(PPW);
  localparam int CW        = (W > 13) ? W + 1 : 14;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_AR, S_RD, S_NEXT_LINE, S_DONE} state_t;
  state_t state_reg, state_next;

  logic [A-1:0] base_reg, stride_reg, line_addr_reg, cur_addr_reg;
  logic [W-1:0] left_reg, width_reg, words_left_reg;
  logic [H-1:0] top_reg, height_reg, row_reg;
  logic         first_beat_reg, rd_err_reg;

  logic [W-1:0]  words_per_line;
  logic [A-1:0]  setup_addr;
  logic [CW-1:0] bound_words, len_c;
  logic          beat, last_beat, line_end;

  assign words_per_line = width_reg >> PPW_SHIFT;
  assign setup_addr     = base_reg + A'(top_reg) * stride_reg + (A'(left_reg) << PIX_SHIFT);

  // Words left before the next 4 KB boundary; a burst must never cross it.
  assign bound_words = (CW'(4096) - CW'(cur_addr_reg[11:0])) >> SIZE;

  always_comb begin
    len_c = CW'(words_left_reg);
    if (len_c > CW'(C_M_AXI_BURST_LEN)) len_c = CW'(C_M_AXI_BURST_LEN);
    if (len_c > bound_words)            len_c = bound_words;
  end

  assign beat      = (state_reg == S_RD) & m_axi_rvalid & ~mm2s_full;
  assign last_beat = beat & m_axi_rlast;
  assign line_end  = last_beat & (CW'(words_left_reg) == len_c);

  always_ff @(posedge m2f_aclk) begin
    if (!resetn) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    busy          = 1'b1;
    frame_done    = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    mm2s_wr_en    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        busy = 1'b0;
        if (frame_start) state_next = S_SETUP;
      end
      S_SETUP: begin
        if (words_per_line == '0 || height_reg == '0) state_next = S_DONE;
        else                                          state_next = S_AR;
      end
      S_AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_next = S_RD;
      end
      S_RD: begin
        m_axi_rready = ~mm2s_full;
        mm2s_wr_en   = beat;
        if (last_beat) begin
          if (!line_end)                         state_next = S_AR;
          else if (row_reg != height_reg - 1'b1) state_next = S_NEXT_LINE;
          else                                   state_next = S_DONE;
        end
      end
      S_NEXT_LINE: state_next = S_AR;
      S_DONE: begin
        frame_done = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge m2f_aclk) begin
    if (!resetn) begin
      base_reg       <= '0;
      stride_reg     <= '0;
      left_reg       <= '0;
      top_reg        <= '0;
      width_reg      <= '0;
      height_reg     <= '0;
      line_addr_reg  <= '0;
      cur_addr_reg   <= '0;
      words_left_reg <= '0;
      row_reg        <= '0;
      first_beat_reg <= 1'b0;
      rd_err_reg     <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (frame_start) begin
            base_reg   <= base_addr;
            stride_reg <= stride;
            left_reg   <= win_left;
            top_reg    <= win_top;
            width_reg  <= win_width;
            height_reg <= win_height;
            rd_err_reg <= 1'b0;
          end
        end
        S_SETUP: begin
          line_addr_reg  <= setup_addr;
          cur_addr_reg   <= setup_addr;
          row_reg        <= '0;
          words_left_reg <= words_per_line;
          first_beat_reg <= 1'b1;
        end
        S_RD: begin
          if (beat) begin
            first_beat_reg <= 1'b0;
            if (m_axi_rresp != 2'b00) rd_err_reg <= 1'b1;
            if (m_axi_rlast) begin
              cur_addr_reg   <= cur_addr_reg + (A'(len_c) << SIZE);
              words_left_reg <= words_left_reg - W'(len_c);
            end
          end
        end
        S_NEXT_LINE: begin
          row_reg        <= row_reg + 1'b1;
          line_addr_reg  <= line_addr_reg + stride_reg;
          cur_addr_reg   <= line_addr_reg + stride_reg;
          words_left_reg <= words_per_line;
        end
        default: ;
      endcase
    end
  end

  assign rd_err        = rd_err_reg;
  assign m_axi_araddr  = cur_addr_reg;
  assign m_axi_arlen   = 8'(len_c - 1'b1);
  assign m_axi_arsize  = 3'(SIZE);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arqos   = 4'b0000;

  genvar gi;
  generate
    for (gi = 0; gi < PPW; gi++) begin : g_slot
      localparam bit IS_FIRST = (gi == 0);
      localparam bit IS_LAST  = (gi == PPW - 1);
      assign mm2s_wr_data[gi*(P+2) +: P+2] =
        {IS_LAST & line_end, IS_FIRST & first_beat_reg, m_axi_rdata[gi*P +: P]};
    end
  endgenerate

endmodule

// File: tb/tb_mm2s_win_reader.sv
// Randomized bench for mm2s_win_reader: AXI read slave with random handshakes,
// FIFO backpressure, and a window/burst reference model built from plain arithmetic.
module tb_mm2s_win_reader;

  localparam int A   = 32;
  localparam int D   = 32;
  localparam int P   = 8;
  localparam int PPW = D / P;
  localparam int SW  = P + 2;
  localparam int WW  = PPW * SW;

  logic          m2f_aclk = 1'b0;
  logic          resetn, frame_start;
  logic [A-1:0]  base_addr, stride;
  logic [11:0]   win_left, win_top, win_width, win_height;
  logic          busy, frame_done, rd_err;
  logic [A-1:0]  araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize, arprot;
  logic [1:0]    arburst;
  logic          arlock, arvalid, arready;
  logic [3:0]    arcache, arqos;
  logic [D-1:0]  rdata;
  logic [1:0]    rresp;
  logic          rlast, rvalid, rready;
  logic          mm2s_full, mm2s_wr_en;
  logic [WW-1:0] mm2s_wr_data;

  always #5 m2f_aclk = ~m2f_aclk;

  mm2s_win_reader dut (
    .m2f_aclk(m2f_aclk), .resetn(resetn), .frame_start(frame_start),
    .base_addr(base_addr), .stride(stride), .win_left(win_left), .win_top(win_top),
    .win_width(win_width), .win_height(win_height),
    .busy(busy), .frame_done(frame_done), .rd_err(rd_err),
    .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
    .m_axi_arprot(arprot), .m_axi_arqos(arqos), .m_axi_arvalid(arvalid),
    .m_axi_arready(arready), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .mm2s_full(mm2s_full), .mm2s_wr_data(mm2s_wr_data), .mm2s_wr_en(mm2s_wr_en)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h3c5a, ~a[15:0]};
  endfunction

  // Slave configuration and observation logs
  int            ar_wait_cfg = 0;
  int            full_pct    = 0;
  int            rvalid_pct  = 75;
  int            err_beat    = -1;
  int            beat_cnt    = 0;
  int            done_cnt    = 0;
  logic [31:0]   got_ar_addr[$];
  int            got_ar_len[$];
  logic [WW-1:0] got_wr[$];

  initial begin : axi_slave
    bit          burst_act, ar_hs, r_hs, prev_wait;
    logic [31:0] b_addr, hs_addr, prev_addr;
    logic [7:0]  prev_len;
    int          b_len, b_idx, ar_wait_cnt, hs_len;
    burst_act = 0; ar_hs = 0; r_hs = 0; prev_wait = 0; ar_wait_cnt = 0;
    b_addr = 0; b_len = 0; b_idx = 0; hs_addr = 0; hs_len = 0; prev_addr = 0; prev_len = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0; mm2s_full = 0;
    forever begin
      @(negedge m2f_aclk);
      if (!resetn) begin
        burst_act = 0; ar_hs = 0; r_hs = 0; prev_wait = 0; ar_wait_cnt = 0;
        arready = 0; rvalid = 0; rlast = 0;
      end else begin
        if (r_hs) begin
          b_idx++;
          beat_cnt++;
          if (b_idx > b_len) burst_act = 0;
        end
        if (ar_hs) begin
          burst_act = 1; b_addr = hs_addr; b_len = hs_len; b_idx = 0; ar_wait_cnt = 0;
        end
        arready = arvalid && !burst_act && (ar_wait_cnt >= ar_wait_cfg);
        if (arvalid && !arready) ar_wait_cnt++;
        if (!burst_act) begin
          rvalid = 0;
          rlast  = 0;
        end else if (!rvalid || r_hs) begin
          rvalid = ($urandom_range(99) < rvalid_pct);
          rdata  = mem_word(b_addr + 32'(4 * b_idx));
          rlast  = (b_idx == b_len);
          rresp  = (beat_cnt == err_beat) ? 2'b10 : 2'b00;
        end
        mm2s_full = ($urandom_range(99) < full_pct);
      end
      #1;
      ar_hs = arvalid & arready;
      r_hs  = rvalid & rready;
      if (ar_hs) begin
        hs_addr = araddr;
        hs_len  = int'(arlen);
        got_ar_addr.push_back(araddr);
        got_ar_len.push_back(int'(arlen));
      end
      if (prev_wait) begin
        check_eq("ar_hold_addr", araddr, prev_addr);
        check_eq("ar_hold_len", arlen, prev_len);
      end
      prev_wait = arvalid & ~arready;
      prev_addr = araddr;
      prev_len  = arlen;
      check_eq("wr_en_vs_handshake", mm2s_wr_en, r_hs);
      check_eq("rready_while_full", rready & mm2s_full, 0);
      if (r_hs) got_wr.push_back(mm2s_wr_data);
      if (frame_done) done_cnt++;
    end
  end

  task automatic tick();
    @(negedge m2f_aclk);
    #2;
  endtask

  task automatic run_frame(input logic [31:0] b, input logic [31:0] s, input int left,
                           input int top, input int w, input int h, input int arw,
                           input int fpct, input int eb, input bit poke);
    logic [31:0]   ea_addr[$];
    int            ea_len[$];
    logic [WW-1:0] ew[$];
    int            start_done, cyc, n;
    got_ar_addr.delete(); got_ar_len.delete(); got_wr.delete();
    ar_wait_cfg = arw; full_pct = fpct; err_beat = eb; beat_cnt = 0;
    tick();
    base_addr = b; stride = s; win_left = 12'(left); win_top = 12'(top);
    win_width = 12'(w); win_height = 12'(h);
    start_done = done_cnt;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check_eq("busy_after_start", busy, 1);
    check_eq("rd_err_cleared", rd_err, 0);
    cyc = 0;
    while (done_cnt == start_done && cyc < 20000) begin
      tick();
      cyc++;
      if (poke && cyc == 10 && busy) begin
        base_addr = 32'h00dead00; win_width = 12'd4; win_height = 12'd1;
        frame_start = 1'b1;
      end
      if (cyc == 11) frame_start = 1'b0;
    end
    check_eq("frame_done_seen", cyc < 20000, 1);
    tick();
    check_eq("done_pulse_count", done_cnt - start_done, 1);
    check_eq("busy_after_done", busy, 0);
    check_eq("frame_done_one_cycle", frame_done, 0);

    for (int r = 0; r < h; r++) begin
      logic [31:0] line, a;
      int nw, rem, l, bnd;
      line = b + 32'(top + r) * s + 32'(left * P / 8);
      nw   = w / PPW;
      a    = line;
      rem  = nw;
      while (rem > 0) begin
        bnd = (4096 - int'(a[11:0])) / (D / 8);
        l = rem;
        if (l > 16)  l = 16;
        if (l > bnd) l = bnd;
        ea_addr.push_back(a);
        ea_len.push_back(l - 1);
        a   = a + 32'(l * (D / 8));
        rem = rem - l;
      end
      for (int j = 0; j < nw; j++) begin
        logic [31:0]   d;
        logic [WW-1:0] e;
        d = mem_word(line + 32'(4 * j));
        for (int k = 0; k < PPW; k++)
          e[k*SW +: SW] = {(k == PPW - 1) && (j == nw - 1),
                           (k == 0) && (j == 0) && (r == 0), d[k*P +: P]};
        ew.push_back(e);
      end
    end

    check_eq("ar_count", got_ar_addr.size(), ea_addr.size());
    n = (got_ar_addr.size() < ea_addr.size()) ? got_ar_addr.size() : ea_addr.size();
    for (int i = 0; i < n; i++) begin
      check_eq("ar_addr", got_ar_addr[i], ea_addr[i]);
      check_eq("ar_len", got_ar_len[i], ea_len[i]);
    end
    check_eq("wr_count", got_wr.size(), ew.size());
    n = (got_wr.size() < ew.size()) ? got_wr.size() : ew.size();
    for (int i = 0; i < n; i++) check_eq("wr_data", got_wr[i], ew[i]);
    check_eq("rd_err_end", rd_err, (eb >= 0) && (eb < ew.size()));
    $display("[TB] frame base=0x%0h stride=0x%0h left=%0d top=%0d w=%0d h=%0d: %0d ARs, %0d writes",
             b, s, left, top, w, h, got_ar_addr.size(), got_wr.size());
  endtask

  initial begin : main
    int cyc;
    resetn = 1'b0; frame_start = 1'b0;
    base_addr = '0; stride = '0; win_left = '0; win_top = '0; win_width = '0; win_height = '0;
    repeat (3) tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_rd_err", rd_err, 0);
    check_eq("rst_arvalid", arvalid, 0);
    check_eq("rst_rready", rready, 0);
    check_eq("rst_wr_en", mm2s_wr_en, 0);
    check_eq("arsize", arsize, 3'd2);
    check_eq("arburst", arburst, 2'b01);
    check_eq("arcache", arcache, 4'b0011);
    check_eq("arlock_prot_qos", {arlock, arprot, arqos}, 0);
    resetn = 1'b1;
    repeat (2) tick();

    // Basic two-line window, partial bursts, 4 KB split, offset window with held arready
    run_frame(32'h1000, 32'h400, 0, 0, 64, 2, 0, 0, -1, 0);
    run_frame(32'h2000, 32'h200, 0, 0, 80, 2, 1, 0, -1, 0);
    run_frame(32'h0ff0, 32'h400, 0, 0, 64, 1, 0, 0, -1, 0);
    run_frame(32'h0000, 32'h100, 8, 3, 32, 2, 5, 0, -1, 0);
    check_eq("offset_first_araddr", (got_ar_addr.size() > 0) ? got_ar_addr[0] : 32'hffffffff, 32'h308);

    // Random windows under 50% FIFO backpressure; the first also pokes frame_start while busy
    for (int t = 0; t < 5; t++) begin
      run_frame($urandom & 32'h000ffffc, 32'h100 + 32'(4 * $urandom_range(0, 1000)),
                4 * $urandom_range(0, 16), $urandom_range(0, 7), 4 * $urandom_range(1, 40),
                $urandom_range(1, 4), $urandom_range(0, 3), 50, -1, t == 0);
    end

    // Error response is sticky until the next frame_start
    run_frame(32'h4000, 32'h100, 0, 0, 32, 2, 0, 20, 5, 0);
    repeat (5) tick();
    check_eq("rd_err_sticky", rd_err, 1);
    run_frame(32'h4000, 32'h100, 0, 0, 32, 2, 0, 0, -1, 0);

    // Empty windows: no AXI traffic, still one frame_done
    run_frame(32'h5000, 32'h100, 0, 0, 64, 0, 0, 0, -1, 0);
    run_frame(32'h5000, 32'h100, 0, 0, 0, 3, 0, 0, -1, 0);

    // Reset in the middle of a read burst
    got_wr.delete(); full_pct = 0; err_beat = -1; ar_wait_cfg = 0;
    base_addr = 32'h3000; stride = 32'h100; win_left = 0; win_top = 0;
    win_width = 12'd64; win_height = 12'd4;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    cyc = 0;
    while (got_wr.size() < 10 && cyc < 2000) begin
      tick();
      cyc++;
    end
    check_eq("midframe_reached", cyc < 2000, 1);
    resetn = 1'b0;
    repeat (2) tick();
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_arvalid", arvalid, 0);
    check_eq("midrst_rready", rready, 0);
    check_eq("midrst_wr_en", mm2s_wr_en, 0);
    resetn = 1'b1;
    repeat (3) tick();
    check_eq("midrst_stays_idle", busy, 0);
    run_frame(32'h1000, 32'h400, 0, 0, 64, 2, 0, 0, -1, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
